// File: rtl/imuldiv_mul_iterative_param.sv
// Iterative shift-add multiplier: one partial product per cycle on operand magnitudes,
// sign applied at the output. Optional early exit once the remaining multiplier is zero.
module imuldiv_mul_iterative_param #(
   parameter int unsigned W          = 32,
   parameter bit          EARLY_TERM = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   mulreq_msg_a,
   input  logic [W-1:0]   mulreq_msg_b,
   input  logic           mulreq_msg_signed,
   input  logic           mulreq_val,
   output logic           mulreq_rdy,
   output logic [2*W-1:0] mulresp_msg_result,
   output logic           mulresp_val,
   input  logic           mulresp_rdy
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t           state, state_nxt;
   logic [2*W-1:0]   a_reg, result;
   logic [W-1:0]     b_reg, b_shift;
   logic [CW-1:0]    counter;
   logic             sign;
   logic [W-1:0]     a_mag, b_mag;
   logic             fire, compute_last;

   // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exact as an unsigned W-bit value
   assign a_mag = (mulreq_msg_signed && mulreq_msg_a[W-1]) ? -mulreq_msg_a : mulreq_msg_a;
   assign b_mag = (mulreq_msg_signed && mulreq_msg_b[W-1]) ? -mulreq_msg_b : mulreq_msg_b;

   assign b_shift      = b_reg >> 1;
   assign fire         = mulreq_val && mulreq_rdy;
   assign compute_last = (counter == '0) || (EARLY_TERM && (b_shift == '0));

   assign mulresp_msg_result = sign ? -result : result;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Ready is also gated by reset so it reads low while reset is held
   always_comb begin
      state_nxt   = state;
      mulreq_rdy  = 1'b0;
      mulresp_val = 1'b0;
      case (state)
         IDLE: begin
            mulreq_rdy = reset;
            if (mulreq_val && reset) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            if (compute_last) state_nxt = DONE;
         end
         DONE: begin
            mulresp_val = 1'b1;
            if (mulresp_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg   <= '0;
         b_reg   <= '0;
         result  <= '0;
         counter <= '0;
         sign    <= 1'b0;
      end else if (state == IDLE) begin
         if (fire) begin
            a_reg   <= {{W{1'b0}}, a_mag};
            b_reg   <= b_mag;
            result  <= '0;
            counter <= CW'(W - 1);
            sign    <= mulreq_msg_signed && (mulreq_msg_a[W-1] ^ mulreq_msg_b[W-1]);
         end
      end else if (state == COMPUTE) begin
         if (b_reg[0]) result <= result + a_reg;
         a_reg   <= a_reg << 1;
         b_reg   <= b_shift;
         counter <= counter - CW'(1);
      end
   end

endmodule

// File: tb/tb_imuldiv_mul_iterative_param.sv
// Directed bench for the iterative multiplier: scoreboard of expected products,
// latency, hold, input-ignore and mid-operation reset checks on W=32 with and without early exit.
module tb_imuldiv_mul_iterative_param;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mulreq_msg_a = '0;
   logic [31:0] mulreq_msg_b = '0;
   logic        mulreq_msg_signed = 1'b0;
   logic        req_val1 = 1'b0, req_val2 = 1'b0;
   logic        req_rdy1, req_rdy2;
   logic [63:0] res1, res2;
   logic        resp_val1, resp_val2;
   logic        resp_rdy = 1'b1;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   imuldiv_mul_iterative_param #(.W(32), .EARLY_TERM(1'b1)) dut_et (
      .clk(clk), .reset(reset),
      .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
      .mulreq_msg_signed(mulreq_msg_signed),
      .mulreq_val(req_val1), .mulreq_rdy(req_rdy1),
      .mulresp_msg_result(res1), .mulresp_val(resp_val1), .mulresp_rdy(resp_rdy)
   );

   imuldiv_mul_iterative_param #(.W(32), .EARLY_TERM(1'b0)) dut_full (
      .clk(clk), .reset(reset),
      .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
      .mulreq_msg_signed(mulreq_msg_signed),
      .mulreq_val(req_val2), .mulreq_rdy(req_rdy2),
      .mulresp_msg_result(res2), .mulresp_val(resp_val2), .mulresp_rdy(resp_rdy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic int exp_n(input logic [31:0] b, input logic s, input bit et);
      logic [31:0] m;
      int n;
      if (!et) return 32;
      m = (s && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return n;
   endfunction

   // sel=0 drives the early-exit instance, sel=1 the full-length one
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit sel, input int hold, input string tag);
      logic [63:0] got, want;
      int  cyc, n_want;
      bit  done;
      exp_q.push_back(model(a, b, s));
      n_want = exp_n(b, s, !sel);
      @(negedge clk);
      mulreq_msg_a = a; mulreq_msg_b = b; mulreq_msg_signed = s;
      if (sel) req_val2 = 1'b1; else req_val1 = 1'b1;
      resp_rdy = (hold == 0);
      chk({tag, "_reqrdy"}, {63'b0, sel ? req_rdy2 : req_rdy1}, 64'd1);
      @(posedge clk); #1;
      req_val1 = 1'b0; req_val2 = 1'b0;
      cyc = 0; done = 1'b0;
      while (!done && cyc < 100) begin
         if (sel) req_val2 = 1'($urandom_range(0, 1)); else req_val1 = 1'($urandom_range(0, 1));
         mulreq_msg_a = $urandom; mulreq_msg_b = $urandom;
         mulreq_msg_signed = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         cyc++;
         done = sel ? resp_val2 : resp_val1;
      end
      req_val1 = 1'b0; req_val2 = 1'b0;
      if (!done) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
         void'(exp_q.pop_front());
         return;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(n_want));
      got = sel ? res2 : res1;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
         return;
      end
      want = exp_q.pop_front();
      chk({tag, "_result"}, got, want);
      for (int i = 0; i < hold; i++) begin
         if (sel) req_val2 = 1'($urandom_range(0, 1)); else req_val1 = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk({tag, "_hold_val"}, {63'b0, sel ? resp_val2 : resp_val1}, 64'd1);
         chk({tag, "_hold_res"}, sel ? res2 : res1, want);
         chk({tag, "_hold_reqrdy"}, {63'b0, sel ? req_rdy2 : req_rdy1}, 64'd0);
      end
      req_val1 = 1'b0; req_val2 = 1'b0;
      resp_rdy = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_idle_rdy"}, {63'b0, sel ? req_rdy2 : req_rdy1}, 64'd1);
      chk({tag, "_idle_val"}, {63'b0, sel ? resp_val2 : resp_val1}, 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_held_rdy", {63'b0, req_rdy1}, 64'd0);
      chk("rst_held_val", {63'b0, resp_val1}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_rst_rdy",    {63'b0, req_rdy1}, 64'd1);
      chk("post_rst_val",    {63'b0, resp_val1}, 64'd0);
      chk("post_rst_res",    res1, 64'd0);
      chk("post_rst_rdy2",   {63'b0, req_rdy2}, 64'd1);

      run_op(32'd3,          32'd5,          1'b0, 1'b0, 0, "u3x5");
      run_op(32'hFFFF_FFF9,  32'd6,          1'b1, 1'b0, 0, "s-7x6");
      run_op(32'hFFFF_FFF9,  32'd6,          1'b0, 1'b0, 0, "u_fff9x6");
      run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 0, "u_max");
      run_op(32'h8000_0000,  32'h8000_0000,  1'b1, 1'b0, 0, "s_min");
      run_op(32'h1234_5678,  32'd0,          1'b1, 1'b0, 0, "b0_et");
      run_op(32'h1234_5678,  32'd0,          1'b0, 1'b1, 0, "b0_full");
      run_op(32'd3,          32'd5,          1'b0, 1'b1, 0, "u3x5_full");
      run_op(32'hFFFF_FFFF,  32'h7FFF_0001,  1'b1, 1'b0, 10, "hold10");
      run_op(32'h0000_0007,  32'hFFFF_FFFE,  1'b1, 1'b0, 0, "s7x-2");

      // Abort an operation mid-compute
      @(negedge clk);
      mulreq_msg_a = 32'h0000_FFFF; mulreq_msg_b = 32'h0000_FFFF; mulreq_msg_signed = 1'b0;
      req_val1 = 1'b1;
      @(posedge clk); #1;
      req_val1 = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("abort_val",  {63'b0, resp_val1}, 64'd0);
      chk("abort_rdy",  {63'b0, req_rdy1}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_rel_rdy", {63'b0, req_rdy1}, 64'd1);
      chk("abort_rel_res", res1, 64'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("no_stale_val", {63'b0, resp_val1}, 64'd0);
      end
      run_op(32'd12, 32'd12, 1'b0, 1'b0, 0, "u12x12");

      for (int k = 0; k < 4; k++)
         run_op($urandom, $urandom, 1'(k & 1), 1'b0, 0, "rand");

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imuldiv_mul_iterative_param.md
IMULDIV_MUL_ITERATIVE_PARAM -- requirements
Module: imuldiv_mul_iterative_param

Interface
REQ-001 SHALL have parameter W, default 32, operand width; legal range 4..64.
REQ-002 SHALL have parameter EARLY_TERM, default 1, enabling early exit when the remaining multiplier is zero.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port mulreq_msg_a  input  W  multiplicand.
REQ-006 SHALL have port mulreq_msg_b  input  W  multiplier.
REQ-007 SHALL have port mulreq_msg_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port mulreq_val  input  1  request valid.
REQ-009 SHALL have port mulreq_rdy  output  1  request ready.
REQ-010 SHALL have port mulresp_msg_result  output  2W  full product.
REQ-011 SHALL have port mulresp_val  output  1  response valid.
REQ-012 SHALL have port mulresp_rdy  input  1  response ready.

Function
REQ-013 SHALL implement three states: IDLE, COMPUTE, DONE; encoding free.
REQ-014 SHALL assert mulreq_rdy only in IDLE; a request fires on a rising edge with mulreq_val=1 and mulreq_rdy=1.
REQ-015 SHALL, on request fire, latch |a| zero-extended to 2W, |b| in W bits, sign = signed & (a[W-1]^b[W-1]), result=0, counter=W-1, and go to COMPUTE.
REQ-016 SHALL, when signed=0, treat the operands as unsigned magnitudes and set sign=0; when signed=1, negate negative operands, and the magnitude of -2^(W-1) is 2^(W-1) in W unsigned bits.
REQ-017 SHALL, on each COMPUTE edge: add a_reg to result if b_reg[0]=1, shift a_reg left 1, shift b_reg right 1, and decrement counter.
REQ-018 SHALL leave COMPUTE for DONE on the edge where counter==0, or, if EARLY_TERM=1, where the shifted b (b_reg>>1) is zero.
REQ-019 SHALL therefore spend N COMPUTE cycles: N=W if EARLY_TERM=0; otherwise N = max(1, index of the highest set bit of |b| + 1).
REQ-020 SHALL assert mulresp_val only in DONE, N+1 cycles after the request-fire cycle.
REQ-021 SHALL drive mulresp_msg_result = sign ? two's-complement negation of result : result, valid whenever mulresp_val=1.
REQ-022 SHALL hold mulresp_msg_result and mulresp_val stable in DONE while mulresp_rdy=0, for any number of cycles.
REQ-023 SHALL go DONE->IDLE on the edge with mulresp_val=1 and mulresp_rdy=1; mulreq_rdy rises the following cycle (no same-cycle accept in DONE).
REQ-024 SHALL ignore mulreq_val and input message changes outside IDLE.
REQ-025 SHALL produce results bit-exact to the full 2W-bit signed or unsigned product, with no overflow possible.

Reset
REQ-026 SHALL, while reset=0, asynchronously force state=IDLE, result/a/b/counter/sign registers to 0, mulresp_val=0, and mulreq_rdy=0.
REQ-027 SHALL, after reset deasserts, present mulreq_rdy=1, mulresp_val=0, and mulresp_msg_result=0.
REQ-028 SHALL abort any in-flight operation on reset assertion in COMPUTE or DONE; no response for it is ever issued.

Verification
REQ-029 SHALL cover: unsigned 3 x 5, W=32, EARLY_TERM=1 -> result 0x0000_0000_0000_000F, N=3, mulresp_val 4 cycles after fire.
REQ-030 SHALL cover: signed -7 x 6 -> result 0xFFFF_FFFF_FFFF_FFD6; the same bits as unsigned operands -> 0x0000_0005_FFFF_FFD6.
REQ-031 SHALL cover: unsigned 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001, N=32; signed 0x8000_0000 x 0x8000_0000 -> 0x4000_0000_0000_0000.
REQ-032 SHALL cover: b=0 with any a -> result 0, N=1 (EARLY_TERM=1) and N=32 (EARLY_TERM=0); mulreq_val toggled during COMPUTE is ignored.
REQ-033 SHALL cover: mulresp_rdy held low 10 cycles in DONE -> result and mulresp_val constant and mulreq_rdy=0 throughout; release -> IDLE next edge.
REQ-034 SHALL cover: reset pulsed low mid-COMPUTE -> mulresp_val=0 and mulreq_rdy=0 immediately; after release, 12 x 12 -> 144 correct, with no stale response.
